// File: rtl/dmem_req_ctrl.sv
// dmem_req_ctrl
// Requester-side controller for the refusing data memory. Takes one load or
// store from the execution unit, issues it to dmem and re-issues it whenever
// dmem refuses. It gives up with an error after MAX_RETRY retries and returns
// load data together with a one-cycle done pulse. The core pipeline is
// stalled for as long as a request is pending and not yet done.

module dmem_req_ctrl #(
  parameter int A_WIDTH   = 13,
  parameter int D_WIDTH   = 34,
  parameter int MAX_RETRY = 3,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_i,
  // core side
  input  logic                 core_req_i,
  input  logic                 core_we_i,
  input  logic [A_WIDTH-1:0]   core_addr_i,
  input  logic [D_WIDTH-1:0]   core_wdata_i,
  output logic                 core_stall_o,
  output logic                 core_done_o,
  output logic [D_WIDTH-1:0]   core_rdata_o,
  output logic                 core_err_o,
  // dmem side
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [A_WIDTH-1:0]   mem_addr_o,
  output logic [D_WIDTH-1:0]   mem_din_o,
  input  logic [D_WIDTH-1:0]   mem_dout_i,
  input  logic                 mem_refused_i,
  // statistics
  output logic [CNT_WIDTH-1:0] refuse_cnt_o
);

  // The retry counter must hold values 0..MAX_RETRY. A minimum width of one
  // bit keeps the declaration legal when retries are disabled.
  localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RETRY_W-1:0]   RETRY_LIMIT = RETRY_W'(MAX_RETRY);
  localparam logic [RETRY_W-1:0]   RETRY_ONE   = RETRY_W'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;

  logic [1:0]           state_q,     state_d;
  logic                 we_q,        we_d;
  logic [A_WIDTH-1:0]   addr_q,      addr_d;
  logic [D_WIDTH-1:0]   wdata_q,     wdata_d;
  logic [RETRY_W-1:0]   retryCnt_q,  retryCnt_d;
  logic [D_WIDTH-1:0]   rdata_q,     rdata_d;
  logic                 done_q,      done_d;
  logic                 err_q,       err_d;
  logic [CNT_WIDTH-1:0] refuseCnt_q, refuseCnt_d;

  logic refuseSat;

  assign refuseSat = &refuseCnt_q;

  // Next-state logic: latch the access in IDLE, issue it, then judge dmem's answer
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    retryCnt_d  = retryCnt_q;
    rdata_d     = rdata_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    refuseCnt_d = refuseCnt_q;

    case (state_q)
      S_IDLE: begin
        // A held request is still high during the done cycle, so it must
        // not be taken again then.
        if (core_req_i && !done_q) begin
          we_d       = core_we_i;
          addr_d     = core_addr_i;
          wdata_d    = core_wdata_i;
          retryCnt_d = '0;
          state_d    = S_ISSUE;
        end
      end

      S_ISSUE: begin
        state_d = S_CHECK;
      end

      S_CHECK: begin
        if (!mem_refused_i) begin
          rdata_d = we_q ? '0 : mem_dout_i;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          if (!refuseSat) begin
            refuseCnt_d = refuseCnt_q + CNT_ONE;
          end
          // A refused store was not written, so re-issuing is the only
          // way to complete it.
          if (retryCnt_q < RETRY_LIMIT) begin
            retryCnt_d = retryCnt_q + RETRY_ONE;
            state_d    = S_ISSUE;
          end else begin
            rdata_d = '1;
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any access in flight
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      retryCnt_q  <= '0;
      rdata_q     <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      refuseCnt_q <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      retryCnt_q  <= retryCnt_d;
      rdata_q     <= rdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
      refuseCnt_q <= refuseCnt_d;
    end
  end

  // The request and write enable depend on state only, so reset drops them at once
  always_comb begin
    mem_req_o = (state_q == S_ISSUE);
    mem_we_o  = (state_q == S_ISSUE) && we_q;
  end

  assign mem_addr_o   = addr_q;
  assign mem_din_o    = wdata_q;

  assign core_stall_o = core_req_i && !done_q;
  assign core_done_o  = done_q;
  assign core_err_o   = err_q;
  assign core_rdata_o = rdata_q;
  assign refuse_cnt_o = refuseCnt_q;

endmodule
